// File: rtl/fma_tv_pkg.sv
// Shared types and vector layout helpers for the FMA test-vector runner.
package fma_tv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } tv_state_t;

    // Bit positions inside the 8-bit ctrl field of a vector word
    localparam int unsigned CTRL_TERM  = 7;
    localparam int unsigned CTRL_RM_HI = 5;
    localparam int unsigned CTRL_RM_LO = 4;
    localparam int unsigned CTRL_MUL   = 3;
    localparam int unsigned CTRL_ADD   = 2;
    localparam int unsigned CTRL_NEGP  = 1;
    localparam int unsigned CTRL_NEGZ  = 0;

    localparam int unsigned FLAGS_W    = 4;
    localparam int unsigned DUT_CTRL_W = 6;

    // Vector word layout, LSB first: flagsexp, rexp, ctrl, z, y, x
    localparam int unsigned OFF_FLAGS = 0;
    localparam int unsigned OFF_REXP  = 4;

    function automatic int unsigned vec_width(input int unsigned flen);
        return 4 * flen + 12;
    endfunction

    function automatic int unsigned off_ctrl(input int unsigned flen);
        return flen + 4;
    endfunction

    function automatic int unsigned off_z(input int unsigned flen);
        return flen + 12;
    endfunction

    function automatic int unsigned off_y(input int unsigned flen);
        return 2 * flen + 12;
    endfunction

    function automatic int unsigned off_x(input int unsigned flen);
        return 3 * flen + 12;
    endfunction

endpackage

// File: rtl/fma_tv_fifo.sv
// Expected-result queue: count-based full/empty, synchronous push/pop.
module fma_tv_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // Qualify requests against the current occupancy
    always_comb begin
        full    = (cnt == (PW+1)'(DEPTH));
        empty   = (cnt == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rp];
        count   = cnt;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop)  rp <= rp + PW'(1);
            cnt <= cnt + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    // Entry storage; contents need no reset since empty gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/fma_vector_runner.sv
// Test-vector sequencer and in-order response checker for the FMA datapath.
module fma_vector_runner
    import fma_tv_pkg::*;
#(
    parameter int unsigned FLEN   = 16,
    parameter int unsigned AW     = 10,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  check_flags,
    input  logic                  stop_on_err,
    output logic                  vec_rd,
    output logic [AW-1:0]         vec_addr,
    input  logic [4*FLEN+11:0]    vec_data,
    output logic                  dut_valid,
    input  logic                  dut_ready,
    output logic [FLEN-1:0]       dut_x,
    output logic [FLEN-1:0]       dut_y,
    output logic [FLEN-1:0]       dut_z,
    output logic [5:0]            dut_ctrl,
    input  logic                  res_valid,
    input  logic [FLEN-1:0]       res,
    input  logic [3:0]            res_flags,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [31:0]           vec_count,
    output logic [31:0]           err_count,
    output logic [AW-1:0]         first_err_idx,
    output logic                  first_err_valid,
    output logic                  proto_err
);
    localparam int unsigned VW = vec_width(FLEN);
    localparam int unsigned OC = off_ctrl(FLEN);
    localparam int unsigned OZ = off_z(FLEN);
    localparam int unsigned OY = off_y(FLEN);
    localparam int unsigned OX = off_x(FLEN);
    localparam int unsigned QW = FLEN + FLAGS_W + AW;
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    tv_state_t         state;
    logic [AW-1:0]     addr;
    logic [VW-1:0]     vec_q;
    logic              chk_q;
    logic              stop_en_q;
    logic              stop_pend;

    logic              q_push;
    logic              q_pop;
    logic [QW-1:0]     q_din;
    logic [QW-1:0]     q_dout;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_count;

    logic              issue_ok;
    logic              accept;
    logic              mismatch;
    logic              proto_hit;
    logic              start_ok;
    logic              drain_fin;
    logic [FLEN-1:0]   exp_res;
    logic [3:0]        exp_flags;
    logic [AW-1:0]     exp_idx;
    logic              ctrl_unused;

    fma_tv_fifo #(
        .W     (QW),
        .DEPTH (QDEPTH)
    ) u_expq (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (q_push),
        .din     (q_din),
        .pop     (q_pop),
        .dout    (q_dout),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    // Handshake, queue control and response comparison
    always_comb begin
        issue_ok  = (state == ST_ISSUE) && !q_full && !stop_pend;
        accept    = issue_ok && dut_ready;
        q_push    = accept;
        q_din     = {vec_q[OFF_REXP +: FLEN], vec_q[OFF_FLAGS +: FLAGS_W], addr};
        q_pop     = res_valid && !q_empty;
        exp_res   = q_dout[AW + FLAGS_W +: FLEN];
        exp_flags = q_dout[AW +: FLAGS_W];
        exp_idx   = q_dout[AW-1:0];
        mismatch  = q_pop && ((res != exp_res) || (chk_q && (res_flags != exp_flags)));
        proto_hit = res_valid && q_empty;
        start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
        // Finishing on the cycle of the final pop makes DONE visible right after it
        drain_fin = res_valid ? (q_count == CW'(1)) : q_empty;
        // ctrl[6] is reserved and the terminator is consumed in LOAD
        ctrl_unused = ^vec_q[OC + 6 +: 2];
    end

    // Sequencer: fetch, load, issue until terminator, address wrap or stop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            vec_q     <= '0;
            chk_q     <= 1'b0;
            stop_en_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        addr      <= '0;
                        chk_q     <= check_flags;
                        stop_en_q <= stop_on_err;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    vec_q <= vec_data;
                    state <= vec_data[OC + CTRL_TERM] ? ST_DRAIN : ST_ISSUE;
                end
                ST_ISSUE: begin
                    // A stop raised after this vector was fetched abandons it unissued
                    if (stop_pend) begin
                        state <= ST_DRAIN;
                    end else if (accept) begin
                        if ((addr == '1) || (mismatch && stop_en_q)) begin
                            state <= ST_DRAIN;
                        end else begin
                            addr  <= addr + AW'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: if (drain_fin) state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Counters, first-error capture and sticky error flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_count       <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            proto_err       <= 1'b0;
            stop_pend       <= 1'b0;
        end else if (start_ok) begin
            vec_count       <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            proto_err       <= 1'b0;
            stop_pend       <= 1'b0;
        end else begin
            if (q_pop) vec_count <= vec_count + 32'd1;
            if ((mismatch || proto_hit) && (err_count != '1)) err_count <= err_count + 32'd1;
            if (mismatch && !first_err_valid) begin
                first_err_idx   <= exp_idx;
                first_err_valid <= 1'b1;
            end
            if (mismatch && stop_en_q) stop_pend <= 1'b1;
            if (proto_hit) proto_err <= 1'b1;
        end
    end

    // Output decode from registered state
    always_comb begin
        vec_rd    = (state == ST_FETCH);
        vec_addr  = addr;
        dut_valid = issue_ok;
        dut_x     = vec_q[OX +: FLEN];
        dut_y     = vec_q[OY +: FLEN];
        dut_z     = vec_q[OZ +: FLEN];
        dut_ctrl  = vec_q[OC +: DUT_CTRL_W];
        busy      = (state != ST_IDLE) && (state != ST_DONE);
        done      = (state == ST_DONE);
        pass      = done && (err_count == '0) && !proto_err;
    end

endmodule

// File: tb/tb_fma_vector_runner.sv
// Directed bench: RAM model, latency/ready-programmable FMA stand-in, assertions.
module tb_fma_vector_runner;
    localparam int FLEN = 16;
    localparam int AW   = 10;
    localparam int VW   = 4*FLEN + 12;
    localparam int NV   = 1024;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic            check_flags;
    logic            stop_on_err;
    logic            vec_rd;
    logic [AW-1:0]   vec_addr;
    logic [VW-1:0]   vec_data;
    logic            dut_valid;
    logic            dut_ready;
    logic [FLEN-1:0] dut_x, dut_y, dut_z;
    logic [5:0]      dut_ctrl;
    logic            res_valid;
    logic [FLEN-1:0] res;
    logic [3:0]      res_flags;
    logic            busy, done, pass;
    logic [31:0]     vec_count, err_count;
    logic [AW-1:0]   first_err_idx;
    logic            first_err_valid, proto_err;

    fma_vector_runner #(.FLEN(FLEN), .AW(AW), .QDEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .check_flags(check_flags),
        .stop_on_err(stop_on_err), .vec_rd(vec_rd), .vec_addr(vec_addr), .vec_data(vec_data),
        .dut_valid(dut_valid), .dut_ready(dut_ready), .dut_x(dut_x), .dut_y(dut_y),
        .dut_z(dut_z), .dut_ctrl(dut_ctrl), .res_valid(res_valid), .res(res),
        .res_flags(res_flags), .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_valid(first_err_valid), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector RAM with one-cycle read latency
    logic [VW-1:0] mem [NV];
    always @(posedge clk) if (vec_rd) vec_data <= mem[vec_addr];

    // Controls written by the main sequence, read by the FMA stand-in
    int        lat = 2;
    bit        ready_mode = 1'b0;
    bit        inject = 1'b0;
    int        clr_seq = 0;
    logic [15:0] resp_res [NV];
    logic [3:0]  resp_flags [NV];

    // Statistics written only by the FMA stand-in
    int        cyc = 0;
    int        acc_n, n_resp, inflight, max_inflight, stall_bad, drop_bad, n_stall;
    logic [15:0] acc_x [NV];
    logic [5:0]  acc_ctrl [NV];
    logic [15:0] acc_y0, acc_z0;
    int        acc_cyc [NV];
    int        resp_cyc [NV];

    typedef struct { int due; logic [15:0] r; logic [3:0] f; } pend_t;

    // FMA stand-in: fixed latency, in-order, optional toggling ready
    initial begin : fma_model
        pend_t pq[$];
        pend_t pe;
        int    seen_seq;
        bit    held_v;
        logic [53:0] held_ops;
        seen_seq = 0; held_v = 1'b0; held_ops = '0;
        acc_n = 0; n_resp = 0; inflight = 0; max_inflight = 0;
        stall_bad = 0; drop_bad = 0; n_stall = 0; acc_y0 = '0; acc_z0 = '0;
        res_valid = 1'b0; res = '0; res_flags = '0; dut_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (seen_seq != clr_seq) begin
                seen_seq = clr_seq;
                acc_n = 0; n_resp = 0; inflight = 0; max_inflight = 0;
                stall_bad = 0; drop_bad = 0; n_stall = 0;
            end
            if (!reset_n) begin
                pq.delete(); inflight = 0; held_v = 1'b0;
            end else begin
                if (held_v) begin
                    if (!dut_valid) drop_bad++;
                    else if ({dut_x, dut_y, dut_z, dut_ctrl} != held_ops) stall_bad++;
                end
                held_v   = dut_valid && !dut_ready;
                held_ops = {dut_x, dut_y, dut_z, dut_ctrl};
                if (held_v) n_stall++;
                if (dut_valid && dut_ready) begin
                    acc_x[acc_n] = dut_x; acc_ctrl[acc_n] = dut_ctrl; acc_cyc[acc_n] = cyc;
                    if (acc_n == 0) begin acc_y0 = dut_y; acc_z0 = dut_z; end
                    pe.due = cyc + lat; pe.r = resp_res[acc_n]; pe.f = resp_flags[acc_n];
                    pq.push_back(pe);
                    acc_n++; inflight++;
                    if (inflight > max_inflight) max_inflight = inflight;
                end
            end
            @(posedge clk);
            cyc++;
            #2;
            res_valid = inject;
            if (reset_n && pq.size() > 0 && pq[0].due <= cyc) begin
                pe = pq.pop_front();
                res_valid = 1'b1; res = pe.r; res_flags = pe.f;
                resp_cyc[n_resp] = cyc; n_resp++; inflight--;
            end
            dut_ready = ready_mode ? cyc[0] : 1'b1;
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run(input bit cf, input bit se);
        clr_seq++;
        check_flags = cf; stop_on_err = se; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k;
        k = 0;
        while (!done && k < lim) begin tick(1); k++; end
        chk(tag, done, 1);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_status"}, {vec_rd, dut_valid, busy, done, pass, first_err_valid, proto_err}, 0);
        chk({p, "_addr"}, vec_addr, 0);
        chk({p, "_vcnt"}, vec_count, 0);
        chk({p, "_ecnt"}, err_count, 0);
        chk({p, "_fidx"}, first_err_idx, 0);
        chk({p, "_ops"}, {dut_x, dut_y, dut_z, dut_ctrl}, 0);
    endtask

    function automatic logic [VW-1:0] mk(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z, input logic [7:0] c,
                                         input logic [15:0] r, input logic [3:0] f);
        return {x, y, z, c, r, f};
    endfunction

    // n mul vectors x=i, rexp=4000+i with matching responses, then a terminator
    task automatic load_table(input int n);
        for (int i = 0; i < n; i++) begin
            mem[i]        = mk(16'(i), 16'h4000, 16'h0000, 8'h08, 16'h4000 + 16'(i), 4'h0);
            resp_res[i]   = 16'h4000 + 16'(i);
            resp_flags[i] = 4'h0;
        end
        mem[n] = mk(16'h0, 16'h0, 16'h0, 8'h80, 16'h0, 4'h0);
    endtask

    initial begin : main
        int k;
        reset_n = 1'b0; start = 1'b0; check_flags = 1'b0; stop_on_err = 1'b0;
        tick(3);
        chk_zero("rst");
        reset_n = 1'b1;
        tick(2);

        // 1.0 * 2.0 + 0.0 = 2.0 then terminator
        mem[0] = mk(16'h3C00, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0);
        mem[1] = mk(16'h0, 16'h0, 16'h0, 8'h80, 16'h0, 4'h0);
        resp_res[0] = 16'h4000; resp_flags[0] = 4'h0;
        lat = 2; ready_mode = 1'b0;
        run(0, 0);
        chk("t1_busy", busy, 1);
        wait_done("t1_done", 100);
        chk("t1_vcnt", vec_count, 1);
        chk("t1_ecnt", err_count, 0);
        chk("t1_pass", pass, 1);
        chk("t1_ops", {acc_x[0], acc_y0, acc_z0, acc_ctrl[0]}, {16'h3C00, 16'h4000, 16'h0000, 6'h08});

        // mismatch 4001 vs 4000 at idx 5, keep going
        load_table(10);
        mem[5] = mk(16'd5, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0);
        resp_res[5] = 16'h4001;
        run(0, 0);
        wait_done("t2_done", 300);
        chk("t2_vcnt", vec_count, 10);
        chk("t2_ecnt", err_count, 1);
        chk("t2_fidx", {first_err_valid, first_err_idx}, {1'b1, 10'd5});
        chk("t2_pass", pass, 0);

        // flags differ only
        load_table(2);
        resp_flags[1] = 4'b0001;
        run(0, 0);
        wait_done("t3a_done", 100);
        chk("t3a_pass", pass, 1);
        chk("t3a_ecnt", err_count, 0);
        run(1, 0);
        wait_done("t3b_done", 100);
        chk("t3b_ecnt", err_count, 1);
        chk("t3b_fidx", {first_err_valid, first_err_idx}, {1'b1, 10'd1});
        chk("t3b_pass", pass, 0);

        // latency 6 with toggling ready
        load_table(12);
        lat = 6; ready_mode = 1'b1;
        run(1, 0);
        wait_done("t4_done", 500);
        chk("t4_vcnt", vec_count, 12);
        chk("t4_pass", pass, 1);
        chk("t4_inflight_le4", max_inflight <= 4, 1);
        chk("t4_stalls_seen", n_stall > 0, 1);
        chk("t4_stable", stall_bad, 0);
        chk("t4_valid_held", drop_bad, 0);
        for (int i = 0; i < 12; i++) chk($sformatf("t4_order%0d", i), acc_x[i], i);

        // long latency fills the queue to exactly its depth
        lat = 20; ready_mode = 1'b0;
        run(1, 0);
        wait_done("t4b_done", 500);
        chk("t4b_maxq", max_inflight, 4);
        chk("t4b_vcnt", vec_count, 12);
        chk("t4b_pass", pass, 1);

        // response with nothing issued
        mem[0] = mk(16'h0, 16'h0, 16'h0, 8'h80, 16'h0, 4'h0);
        lat = 2;
        run(0, 0);
        inject = 1'b1;
        tick(1);
        inject = 1'b0;
        wait_done("t5_done", 100);
        chk("t5_proto", proto_err, 1);
        chk("t5_ecnt", err_count, 1);
        chk("t5_vcnt", vec_count, 0);
        chk("t5_pass", pass, 0);

        // stop on error at idx 2: idx3 issues before the response, idx4 never
        load_table(10);
        resp_res[2] = 16'h4003;
        lat = 4;
        run(0, 1);
        wait_done("t6_done", 300);
        chk("t6_issued", acc_n, 4);
        chk("t6_vcnt", vec_count, 4);
        chk("t6_ecnt", err_count, 1);
        chk("t6_fidx", {first_err_valid, first_err_idx}, {1'b1, 10'd2});
        chk("t6_no_late_issue", acc_cyc[3] <= resp_cyc[2], 1);

        // reset in the middle of a run with an error already logged
        load_table(10);
        mem[5] = mk(16'd5, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0);
        resp_res[5] = 16'h4001;
        lat = 2;
        run(0, 0);
        k = 0;
        while (err_count == 0 && k < 300) begin tick(1); k++; end
        chk("t7_err_before_rst", err_count, 1);
        reset_n = 1'b0;
        #1;
        chk_zero("t7");
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk("t7_idle_after", {busy, done, proto_err}, 0);

        // full address space without terminator stops at the last address
        for (int i = 0; i < NV; i++) begin
            mem[i]        = mk(16'(i), 16'h3C00, 16'h0000, 8'h04, 16'(i), 4'(i));
            resp_res[i]   = 16'(i);
            resp_flags[i] = 4'(i);
        end
        run(1, 0);
        wait_done("t8_done", 5000);
        chk("t8_vcnt", vec_count, 1024);
        chk("t8_addr", vec_addr, 10'h3FF);
        chk("t8_pass", pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
